// File: rtl/trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer
//
// Circular trace buffer for retired-instruction samples. After an arm pulse it
// records every valid sample into a DEPTH-entry ring, waits for a programmable
// trigger, keeps capturing POST_TRIGGER further samples and then streams the
// buffer out oldest-first over a valid/ready interface.
//
// Ports
//   clk, reset_n            single rising-edge clock, async active-low reset
//   sample_*                retired instruction (valid, pc, instr, acc,
//                           status, branch_taken)
//   arm / abort             start a capture / return to IDLE from anywhere
//   trig_mode               00 immediate, 01 PC match, 10 branch taken,
//                           11 status & mask nonzero
//   trig_pc, trig_status_mask  trigger operands
//   rd_valid/rd_ready/rd_data/rd_last  readout stream,
//                           rd_data = {pc, instr, acc, status, branch_taken}
//   state                   current FSM state
//   trig_pos                readout index of the trigger entry
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for arm; samples ignored
// ARMED | capturing every valid sample, watching for the trigger
// POST  | capturing the remaining post-trigger samples
// DONE  | capture frozen; buffer streamed out, back to IDLE after last
// -----------------------------------------------------------------------------
module trace_capture_buffer #(
    parameter int PC_WIDTH     = 10,
    parameter int INSTR_WIDTH  = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 64,
    parameter int POST_TRIGGER = 32
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            sample_valid,
    input  logic [PC_WIDTH-1:0]                             sample_pc,
    input  logic [INSTR_WIDTH-1:0]                          sample_instr,
    input  logic [DATA_WIDTH-1:0]                           sample_acc,
    input  logic [DATA_WIDTH-1:0]                           sample_status,
    input  logic                                            sample_branch_taken,
    input  logic                                            arm,
    input  logic                                            abort,
    input  logic [1:0]                                      trig_mode,
    input  logic [PC_WIDTH-1:0]                             trig_pc,
    input  logic [DATA_WIDTH-1:0]                           trig_status_mask,
    output logic                                            rd_valid,
    input  logic                                            rd_ready,
    output logic [PC_WIDTH+INSTR_WIDTH+2*DATA_WIDTH:0]      rd_data,
    output logic                                            rd_last,
    output logic [1:0]                                      state,
    output logic [$clog2(DEPTH)-1:0]                        trig_pos
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int EW = PC_WIDTH + INSTR_WIDTH + 2*DATA_WIDTH + 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_POST  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
    localparam logic [FW-1:0] POST_CNT = FW'(POST_TRIGGER);

    logic [EW-1:0] mem [DEPTH];

    logic [1:0]    state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [FW-1:0] fill_q,     fill_d;
    logic [FW-1:0] cnt_q,      cnt_d;
    logic [AW-1:0] trig_pos_q, trig_pos_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [FW-1:0] rd_left_q,  rd_left_d;
    logic          rd_busy_q,  rd_busy_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q,  rd_last_d;
    logic [EW-1:0] rd_data_q,  rd_data_d;

    logic          trig_hit;
    logic          wr_en;
    logic [EW-1:0] sample_entry;
    logic [FW-1:0] fill_inc;
    logic [FW-1:0] trig_pos_full;
    logic [AW-1:0] rd_start;

    assign sample_entry = {sample_pc, sample_instr, sample_acc, sample_status,
                           sample_branch_taken};

    always_comb begin
        trig_hit = 1'b0;
        unique case (trig_mode)
            2'b00:   trig_hit = 1'b1;
            2'b01:   trig_hit = (sample_pc == trig_pc);
            2'b10:   trig_hit = sample_branch_taken;
            default: trig_hit = (trig_status_mask != '0) &&
                                ((sample_status & trig_status_mask) != '0);
        endcase
    end

    // Abort wins over everything, including the write of a concurrent sample.
    assign wr_en = sample_valid && !abort &&
                   ((state_q == ST_ARMED) || (state_q == ST_POST));

    assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);

    // Trigger index within the readout, from the fill level including the
    // write that closes the capture. Never negative: the trigger and every
    // post-trigger sample are still inside the ring.
    assign trig_pos_full = fill_inc - FW'(1) - POST_CNT;

    // Until the ring has wrapped the oldest entry sits at index 0.
    assign rd_start = (fill_q == FILL_MAX) ? wr_ptr_q : '0;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        trig_pos_d = trig_pos_q;
        rd_ptr_d   = rd_ptr_q;
        rd_left_d  = rd_left_q;
        rd_busy_d  = rd_busy_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;

        if (abort) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            rd_busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d    = ST_ARMED;
                        wr_ptr_d   = '0;
                        fill_d     = '0;
                        cnt_d      = '0;
                        trig_pos_d = '0;
                        rd_busy_d  = 1'b0;
                    end
                end

                ST_ARMED: begin
                    if (wr_en) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        fill_d   = fill_inc;
                        if (trig_hit) begin
                            if (POST_TRIGGER == 0) begin
                                state_d    = ST_DONE;
                                trig_pos_d = trig_pos_full[AW-1:0];
                            end else begin
                                state_d = ST_POST;
                                cnt_d   = POST_CNT;
                            end
                        end
                    end
                end

                ST_POST: begin
                    if (wr_en) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        fill_d   = fill_inc;
                        cnt_d    = cnt_q - FW'(1);
                        if (cnt_q == FW'(1)) begin
                            state_d    = ST_DONE;
                            trig_pos_d = trig_pos_full[AW-1:0];
                        end
                    end
                end

                default: begin
                    // First DONE cycle fetches the oldest entry; rd_valid
                    // therefore rises on the second DONE cycle.
                    if (!rd_busy_q) begin
                        rd_busy_d  = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem[rd_start];
                        rd_ptr_d   = rd_start + AW'(1);
                        rd_left_d  = fill_q - FW'(1);
                        rd_last_d  = (fill_q == FW'(1));
                    end else if (rd_valid_q && rd_ready) begin
                        if (rd_last_q) begin
                            state_d    = ST_IDLE;
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            rd_busy_d  = 1'b0;
                        end else begin
                            rd_data_d = mem[rd_ptr_q];
                            rd_ptr_d  = rd_ptr_q + AW'(1);
                            rd_left_d = rd_left_q - FW'(1);
                            rd_last_d = (rd_left_q == FW'(1));
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            trig_pos_q <= '0;
            rd_ptr_q   <= '0;
            rd_left_q  <= '0;
            rd_busy_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            trig_pos_q <= trig_pos_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_left_q  <= rd_left_d;
            rd_busy_q  <= rd_busy_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage is not reset; only entries written since the last arm are read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_entry;
        end
    end

    assign state    = state_q;
    assign trig_pos = trig_pos_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
module tb_trace_capture_buffer;

    localparam int PW = 10;
    localparam int IW = 16;
    localparam int DW = 8;
    localparam int EW = PW + IW + 2*DW + 1;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sample_valid;
    logic [PW-1:0] sample_pc;
    logic [IW-1:0] sample_instr;
    logic [DW-1:0] sample_acc;
    logic [DW-1:0] sample_status;
    logic          sample_branch_taken;
    logic          arm;
    logic          abort;
    logic [1:0]    trig_mode;
    logic [PW-1:0] trig_pc;
    logic [DW-1:0] trig_status_mask;
    logic          rd_ready;
    int            sel;

    logic          arm_a, arm_b, arm_c, rdy_a, rdy_b, rdy_c;
    logic          vld_a, vld_b, vld_c, lst_a, lst_b, lst_c;
    logic [EW-1:0] dat_a, dat_b, dat_c;
    logic [1:0]    st_a, st_b, st_c;
    logic [AW-1:0] tp_a, tp_b, tp_c;

    logic          s_valid, s_last;
    logic [EW-1:0] s_data;
    logic [1:0]    s_state;
    logic [AW-1:0] s_tp;

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    assign arm_a = arm & (sel == 0);
    assign arm_b = arm & (sel == 1);
    assign arm_c = arm & (sel == 2);
    assign rdy_a = rd_ready & (sel == 0);
    assign rdy_b = rd_ready & (sel == 1);
    assign rdy_c = rd_ready & (sel == 2);

    always_comb begin
        s_valid = vld_a; s_last = lst_a; s_data = dat_a; s_state = st_a; s_tp = tp_a;
        if (sel == 1) begin
            s_valid = vld_b; s_last = lst_b; s_data = dat_b; s_state = st_b; s_tp = tp_b;
        end else if (sel == 2) begin
            s_valid = vld_c; s_last = lst_c; s_data = dat_c; s_state = st_c; s_tp = tp_c;
        end
    end

    trace_capture_buffer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DATA_WIDTH(DW),
                           .DEPTH(8), .POST_TRIGGER(3)) u_a (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_pc(sample_pc), .sample_instr(sample_instr), .sample_acc(sample_acc),
        .sample_status(sample_status), .sample_branch_taken(sample_branch_taken),
        .arm(arm_a), .abort(abort), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_status_mask(trig_status_mask), .rd_valid(vld_a), .rd_ready(rdy_a),
        .rd_data(dat_a), .rd_last(lst_a), .state(st_a), .trig_pos(tp_a));

    trace_capture_buffer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DATA_WIDTH(DW),
                           .DEPTH(8), .POST_TRIGGER(0)) u_b (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_pc(sample_pc), .sample_instr(sample_instr), .sample_acc(sample_acc),
        .sample_status(sample_status), .sample_branch_taken(sample_branch_taken),
        .arm(arm_b), .abort(abort), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_status_mask(trig_status_mask), .rd_valid(vld_b), .rd_ready(rdy_b),
        .rd_data(dat_b), .rd_last(lst_b), .state(st_b), .trig_pos(tp_b));

    trace_capture_buffer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DATA_WIDTH(DW),
                           .DEPTH(8), .POST_TRIGGER(2)) u_c (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_pc(sample_pc), .sample_instr(sample_instr), .sample_acc(sample_acc),
        .sample_status(sample_status), .sample_branch_taken(sample_branch_taken),
        .arm(arm_c), .abort(abort), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_status_mask(trig_status_mask), .rd_valid(vld_c), .rd_ready(rdy_c),
        .rd_data(dat_c), .rd_last(lst_c), .state(st_c), .trig_pos(tp_c));

    typedef struct {
        logic [1:0]    mode;
        logic [PW-1:0] tpc;
        logic [DW-1:0] mask;
        logic          valid;
        logic [PW-1:0] pc;
        logic [DW-1:0] status;
        logic          br;
        logic [1:0]    exp_state;
    } trig_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] ent(input int pc, input logic [7:0] st, input logic br);
        logic [PW-1:0] p;
        logic [IW-1:0] ins;
        logic [DW-1:0] acc;
        p   = pc[PW-1:0];
        ins = 16'hA000 + 16'(pc);
        acc = 8'(pc * 3);
        return {p, ins, acc, st, br};
    endfunction

    task automatic put(input int pc, input logic [7:0] st, input logic br);
        sample_valid        = 1'b1;
        sample_pc           = pc[PW-1:0];
        sample_instr        = 16'hA000 + 16'(pc);
        sample_acc          = 8'(pc * 3);
        sample_status       = st;
        sample_branch_taken = br;
        tick();
        sample_valid        = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic readout(input string nm, input bit bp);
        int got = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [EW-1:0] hold_d = '0;
        logic hold_l = 1'b0;
        while (got < exp_q.size() && cyc < 300) begin
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk({nm, "/stall_valid"}, 64'(s_valid), 64'(1));
                chk({nm, "/stall_data"}, 64'(s_data), 64'(hold_d));
                chk({nm, "/stall_last"}, 64'(s_last), 64'(hold_l));
            end
            stalled = 0;
            if (s_valid) begin
                if (rd_ready) begin
                    chk({nm, "/data"}, 64'(s_data), 64'(exp_q[got]));
                    chk({nm, "/last"}, 64'(s_last), 64'(got == exp_q.size() - 1));
                    got++;
                end else begin
                    stalled = 1;
                    hold_d  = s_data;
                    hold_l  = s_last;
                end
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        chk({nm, "/count"}, 64'(got), 64'(exp_q.size()));
        chk({nm, "/end_state"}, 64'(s_state), 64'(2'b00));
        chk({nm, "/end_valid"}, 64'(s_valid), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        trig_vec_t tv[9];
        tv[0] = '{2'b00, 10'd5, 8'h00, 1'b1, 10'd9, 8'h00, 1'b0, 2'b10};
        tv[1] = '{2'b01, 10'd5, 8'h00, 1'b1, 10'd5, 8'h00, 1'b0, 2'b10};
        tv[2] = '{2'b01, 10'd5, 8'h00, 1'b1, 10'd6, 8'h00, 1'b1, 2'b01};
        tv[3] = '{2'b10, 10'd5, 8'h00, 1'b1, 10'd6, 8'h00, 1'b1, 2'b10};
        tv[4] = '{2'b10, 10'd5, 8'h00, 1'b1, 10'd5, 8'h00, 1'b0, 2'b01};
        tv[5] = '{2'b11, 10'd5, 8'h04, 1'b1, 10'd1, 8'h04, 1'b0, 2'b10};
        tv[6] = '{2'b11, 10'd5, 8'h04, 1'b1, 10'd1, 8'hFB, 1'b1, 2'b01};
        tv[7] = '{2'b11, 10'd5, 8'h00, 1'b1, 10'd5, 8'hFF, 1'b1, 2'b01};
        tv[8] = '{2'b01, 10'd5, 8'h00, 1'b0, 10'd5, 8'h00, 1'b0, 2'b01};

        sel = 0; reset_n = 1'b0; sample_valid = 1'b0; sample_pc = '0;
        sample_instr = '0; sample_acc = '0; sample_status = '0;
        sample_branch_taken = 1'b0; arm = 1'b0; abort = 1'b0; trig_mode = 2'b00;
        trig_pc = '0; trig_status_mask = '0; rd_ready = 1'b0;

        tick(); tick();
        chk("reset/state", 64'(s_state), 64'(0));
        chk("reset/rd_valid", 64'(s_valid), 64'(0));
        chk("reset/rd_last", 64'(s_last), 64'(0));
        chk("reset/rd_data", 64'(s_data), 64'(0));
        chk("reset/trig_pos", 64'(s_tp), 64'(0));
        reset_n = 1'b1;
        tick();

        // Samples without arm are ignored.
        put(3, 8'h00, 1'b1);
        chk("idle_ignores_sample", 64'(s_state), 64'(0));

        // Trigger decode, one sample per vector, DEPTH=8/POST=3 instance.
        for (int i = 0; i < 9; i++) begin
            do_abort();
            trig_mode = tv[i].mode; trig_pc = tv[i].tpc; trig_status_mask = tv[i].mask;
            do_arm();
            sample_valid        = tv[i].valid;
            sample_pc           = tv[i].pc;
            sample_status       = tv[i].status;
            sample_branch_taken = tv[i].br;
            tick();
            sample_valid = 1'b0;
            chk($sformatf("trig_vec%0d", i), 64'(s_state), 64'(tv[i].exp_state));
        end
        do_abort();

        // PC match with wrap: pc 0..20, trigger at 5, three post samples.
        trig_mode = 2'b01; trig_pc = 10'd5; trig_status_mask = 8'h00;
        do_arm();
        chk("pcm/armed", 64'(s_state), 64'(2'b01));
        for (int pc = 0; pc <= 20; pc++) begin
            put(pc, 8'h00, 1'b0);
            if (pc == 8) begin
                chk("pcm/done", 64'(s_state), 64'(2'b11));
                chk("pcm/valid_first_done_cycle", 64'(s_valid), 64'(0));
            end
            if (pc == 9) chk("pcm/valid_second_done_cycle", 64'(s_valid), 64'(1));
        end
        chk("pcm/trig_pos", 64'(s_tp), 64'(4));
        exp_q.delete();
        for (int pc = 1; pc <= 8; pc++) exp_q.push_back(ent(pc, 8'h00, 1'b0));
        readout("pcm", 1'b0);

        // Immediate trigger, no post-trigger samples.
        sel = 1; trig_mode = 2'b00;
        do_arm();
        put(7, 8'h00, 1'b0);
        chk("imm/done", 64'(s_state), 64'(2'b11));
        chk("imm/trig_pos", 64'(s_tp), 64'(0));
        exp_q.delete();
        exp_q.push_back(ent(7, 8'h00, 1'b0));
        readout("imm", 1'b0);

        // Branch trigger on third sample, two post samples, no wrap.
        sel = 2; trig_mode = 2'b10;
        do_arm();
        put(10, 8'h00, 1'b0); put(11, 8'h00, 1'b0); put(12, 8'h00, 1'b1);
        chk("br/post", 64'(s_state), 64'(2'b10));
        put(13, 8'h00, 1'b0); put(14, 8'h00, 1'b0);
        chk("br/done", 64'(s_state), 64'(2'b11));
        chk("br/trig_pos", 64'(s_tp), 64'(2));
        exp_q.delete();
        exp_q.push_back(ent(10, 8'h00, 1'b0));
        exp_q.push_back(ent(11, 8'h00, 1'b0));
        exp_q.push_back(ent(12, 8'h00, 1'b1));
        exp_q.push_back(ent(13, 8'h00, 1'b0));
        exp_q.push_back(ent(14, 8'h00, 1'b0));
        readout("br", 1'b1);

        // Abort in POST, then a clean capture.
        sel = 0; trig_mode = 2'b00;
        do_arm();
        put(30, 8'h00, 1'b0);
        put(31, 8'h00, 1'b0);
        chk("abort/in_post", 64'(s_state), 64'(2'b10));
        do_abort();
        chk("abort/state", 64'(s_state), 64'(0));
        chk("abort/valid", 64'(s_valid), 64'(0));
        do_arm();
        for (int pc = 40; pc <= 43; pc++) put(pc, 8'h00, 1'b0);
        chk("abort/recap_done", 64'(s_state), 64'(2'b11));
        chk("abort/recap_trig_pos", 64'(s_tp), 64'(0));
        exp_q.delete();
        for (int pc = 40; pc <= 43; pc++) exp_q.push_back(ent(pc, 8'h00, 1'b0));
        readout("abort_recap", 1'b0);

        // Reset in the middle of a readout.
        do_arm();
        for (int pc = 44; pc <= 47; pc++) put(pc, 8'h00, 1'b0);
        rd_ready = 1'b1;
        tick(); tick(); tick();
        rd_ready = 1'b0;
        chk("rst_mid/was_reading", 64'(s_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("rst_mid/state", 64'(s_state), 64'(0));
        chk("rst_mid/valid", 64'(s_valid), 64'(0));
        chk("rst_mid/data", 64'(s_data), 64'(0));
        chk("rst_mid/trig_pos", 64'(s_tp), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        put(48, 8'h00, 1'b0);
        chk("rst_mid/needs_arm", 64'(s_state), 64'(0));
        do_arm();
        for (int pc = 50; pc <= 53; pc++) put(pc, 8'h00, 1'b0);
        chk("rst_mid/recap_trig_pos", 64'(s_tp), 64'(0));
        exp_q.delete();
        for (int pc = 50; pc <= 53; pc++) exp_q.push_back(ent(pc, 8'h00, 1'b0));
        readout("rst_recap", 1'b0);

        // Status-mask trigger on the 10th sample: wrapped ring, backpressure.
        trig_mode = 2'b11; trig_status_mask = 8'h04;
        do_arm();
        for (int pc = 60; pc <= 72; pc++) put(pc, (pc == 69) ? 8'h0F : 8'h0B, 1'b0);
        chk("stm/done", 64'(s_state), 64'(2'b11));
        chk("stm/trig_pos", 64'(s_tp), 64'(4));
        exp_q.delete();
        for (int pc = 65; pc <= 72; pc++)
            exp_q.push_back(ent(pc, (pc == 69) ? 8'h0F : 8'h0B, 1'b0));
        readout("stm", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_capture_buffer.md
TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, program-counter width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16, instruction width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, accumulator and status width.
REQ-004 SHALL have parameter DEPTH, default 64, entry count; power of two, at least 4.
REQ-005 SHALL have parameter POST_TRIGGER, default 32, entries captured after the trigger entry; 0 to DEPTH-1.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port sample_valid, input, 1, one retired instruction this cycle.
REQ-009 SHALL have ports sample_pc (PC_WIDTH), sample_instr (INSTR_WIDTH), sample_acc (DATA_WIDTH), sample_status (DATA_WIDTH), sample_branch_taken (1), all inputs, describing the retired instruction.
REQ-010 SHALL have port arm, input, 1, start-capture pulse.
REQ-011 SHALL have port abort, input, 1, return to IDLE.
REQ-012 SHALL have port trig_mode, input, 2: 00 immediate, 01 PC match, 10 branch taken, 11 status match.
REQ-013 SHALL have ports trig_pc (PC_WIDTH) and trig_status_mask (DATA_WIDTH), both inputs, trigger operands.
REQ-014 SHALL have ports rd_valid (output, 1), rd_ready (input, 1), rd_data (output, PC_WIDTH+INSTR_WIDTH+2*DATA_WIDTH+1), rd_last (output, 1), forming the readout stream.
REQ-015 SHALL have port state, output, 2: 00 IDLE, 01 ARMED, 10 POST, 11 DONE.
REQ-016 SHALL have port trig_pos, output, clog2(DEPTH), readout index of the trigger entry.

Function
REQ-017 SHALL pack rd_data as {pc, instr, acc, status, branch_taken}, MSB first.
REQ-018 SHALL leave IDLE only on arm; arm SHALL clear the write pointer and fill count and enter ARMED next cycle.
REQ-019 SHALL write each sample_valid cycle in ARMED or POST at wr_ptr.
REQ-020 SHALL increment wr_ptr modulo DEPTH, wrap to 0 after DEPTH-1, and saturate fill count at DEPTH.
REQ-021 SHALL evaluate the trigger in ARMED only, on a sample_valid cycle.
REQ-022 SHALL define a trigger hit per mode: 00 any sample; 01 sample_pc==trig_pc; 10 sample_branch_taken==1; 11 (sample_status & trig_status_mask)!=0 with a nonzero mask.
REQ-023 SHALL write the trigger sample itself, then enter POST with counter=POST_TRIGGER, or enter DONE directly when POST_TRIGGER==0.
REQ-024 SHALL decrement the counter per written sample in POST and enter DONE on the cycle after the write that reaches 0.
REQ-025 SHALL ignore sample_valid in IDLE and DONE, and SHALL ignore arm outside IDLE.
REQ-026 SHALL have abort force IDLE next cycle from any state, take priority over arm and trigger, and deassert rd_valid.
REQ-027 SHALL start readout at the oldest entry: index 0 if fill<DEPTH, else wr_ptr.
REQ-028 SHALL read out exactly fill entries in capture order.
REQ-029 SHALL assert rd_valid first on the second cycle in DONE.
REQ-030 SHALL transfer an entry on rd_valid&&rd_ready and SHALL sustain back-to-back transfers, one per cycle.
REQ-031 SHALL hold rd_data and rd_last stable while rd_valid&&!rd_ready.
REQ-032 SHALL assert rd_last with the final entry and return to IDLE the cycle after its handshake.
REQ-033 SHALL compute trig_pos = fill-1-POST_TRIGGER at DONE entry and hold it until the next arm.

Reset
REQ-034 SHALL asynchronously, while reset_n=0, force state=IDLE, wr_ptr=0, fill=0, counter=0, trig_pos=0, rd_valid=0, rd_last=0 and rd_data=0; memory contents are undefined.
REQ-035 SHALL discard any in-progress capture or readout on reset mid-operation.
REQ-036 SHALL require a fresh arm after reset release.

Verification
REQ-037 SHALL verify: DEPTH=8, POST_TRIGGER=3, mode 01, trig_pc=5, pc 0..20 one per cycle -> DONE, 8 entries pc 1..8, trig_pos=4, rd_last on pc 8.
REQ-038 SHALL verify: mode 00, POST_TRIGGER=0, arm then one sample pc=7 -> 1 entry, rd_last on it, trig_pos=0.
REQ-039 SHALL verify: mode 10, branch_taken only on 3rd sample, POST_TRIGGER=2 -> 5 entries with no wrap, start index 0, trig_pos=2.
REQ-040 SHALL verify: random rd_ready backpressure during readout -> rd_data stable while stalled, every entry delivered exactly once, in order.
REQ-041 SHALL verify: abort in POST, and reset_n low mid-readout -> state=IDLE, rd_valid=0; next arm captures cleanly with fill starting at 0.
REQ-042 SHALL verify: mode 11, mask=0x04, status bit2 set on 10th sample with DEPTH=8 -> wrapped buffer, oldest-first order across wrap.
